// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcodes, ALU operation classes and
// bit positions inside the packed wb/mem control fields.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // wb field = {regwrite, memtoreg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // mem field = {branch, memread, memwrite}
    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

endpackage

// File: rtl/decode_stage_p_reg_file.sv
// Register file for the ID stage.
// Ports:
//   clk, rst        - clock and synchronous active-high reset (clears all registers)
//   read_addr_a/b   - asynchronous read indices
//   read_data_a/b   - read data; index 0 returns 0, same-cycle writeback is bypassed
//   write_addr      - writeback index (writes to 0 are ignored)
//   write_data      - writeback data
//   write_en        - writeback enable
module reg_file_p #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RAW-1:0]  read_addr_a,
    input  logic [RAW-1:0]  read_addr_b,
    output logic [XLEN-1:0] read_data_a,
    output logic [XLEN-1:0] read_data_b,
    input  logic [RAW-1:0]  write_addr,
    input  logic [XLEN-1:0] write_data,
    input  logic            write_en
);

    logic [XLEN-1:0] regs [NREG];
    logic            write_ok;

    // Index 0 is never written, and indices beyond NREG are ignored.
    assign write_ok = write_en && (write_addr != '0) && (int'(write_addr) < NREG);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[write_addr] <= write_data;
        end
    end

    // Write-through: the value being written back this cycle is visible
    // to readers in the same cycle, so the ID stage never sees stale data.
    function automatic logic [XLEN-1:0] read_port(input logic [RAW-1:0] addr);
        logic [XLEN-1:0] value;
        value = '0;
        if (addr == '0 || int'(addr) >= NREG) begin
            value = '0;
        end else if (write_ok && write_addr == addr) begin
            value = write_data;
        end else begin
            value = regs[addr];
        end
        return value;
    endfunction

    assign read_data_a = read_port(read_addr_a);
    assign read_data_b = read_port(read_addr_b);

endmodule

// File: rtl/decode_stage_p.sv
// ID stage of the 5-stage MIPS pipeline: control decode, operand read,
// immediate sign extension, load-use hazard detection and the ID/EX register.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   pc_4, instr, instr_valid        - IF/ID contents
//   write_reg_MEMWB, write_data_WB,
//   write_en                        - writeback port into the register file
//   flush                           - squash from a taken branch
//   stall                           - combinational load-use stall request
//   *_IDEX, valid_IDEX              - registered ID/EX contents
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_4,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    input  logic [RAW-1:0]  write_reg_MEMWB,
    input  logic [XLEN-1:0] write_data_WB,
    input  logic            write_en,
    input  logic            flush,
    output logic            stall,
    output logic            valid_IDEX,
    output logic [1:0]      wb_IDEX,
    output logic [2:0]      mem_IDEX,
    output logic [1:0]      aluop_IDEX,
    output logic            alusrc_IDEX,
    output logic            regdst_IDEX,
    output logic [XLEN-1:0] pc_4_IDEX,
    output logic [XLEN-1:0] rs_IDEX,
    output logic [XLEN-1:0] rt_IDEX,
    output logic [XLEN-1:0] signExt_IDEX,
    output logic [RAW-1:0]  instr25_21_IDEX,
    output logic [RAW-1:0]  instr20_16_IDEX,
    output logic [RAW-1:0]  instr15_11_IDEX
);

    logic [5:0]      opcode;
    logic [RAW-1:0]  rs_idx;
    logic [RAW-1:0]  rt_idx;
    logic [RAW-1:0]  rd_idx;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] sign_ext;

    logic [1:0] wb_next;
    logic [2:0] mem_next;
    logic [1:0] aluop_next;
    logic       alusrc_next;
    logic       regdst_next;

    assign opcode   = instr[31:26];
    assign rs_idx   = RAW'(instr[25:21]);
    assign rt_idx   = RAW'(instr[20:16]);
    assign rd_idx   = RAW'(instr[15:11]);
    assign sign_ext = {{(XLEN-16){instr[15]}}, instr[15:0]};

    reg_file_p #(
        .XLEN(XLEN),
        .NREG(NREG),
        .RAW (RAW)
    ) u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .read_addr_a(rs_idx),
        .read_addr_b(rt_idx),
        .read_data_a(rs_data),
        .read_data_b(rt_data),
        .write_addr (write_reg_MEMWB),
        .write_data (write_data_WB),
        .write_en   (write_en)
    );

    // Control decode; an invalid slot decodes as a NOP.
    always_comb begin
        wb_next     = '0;
        mem_next    = '0;
        aluop_next  = ALUOP_ADD;
        alusrc_next = 1'b0;
        regdst_next = 1'b0;
        if (instr_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    wb_next[WB_REGWRITE] = 1'b1;
                    aluop_next           = ALUOP_FUNCT;
                    regdst_next          = 1'b1;
                end
                OP_LW: begin
                    wb_next[WB_REGWRITE] = 1'b1;
                    wb_next[WB_MEMTOREG] = 1'b1;
                    mem_next[MEM_READ]   = 1'b1;
                    alusrc_next          = 1'b1;
                end
                OP_SW: begin
                    mem_next[MEM_WRITE] = 1'b1;
                    alusrc_next         = 1'b1;
                end
                OP_BEQ: begin
                    mem_next[MEM_BRANCH] = 1'b1;
                    aluop_next           = ALUOP_SUB;
                end
                OP_ADDI: begin
                    wb_next[WB_REGWRITE] = 1'b1;
                    alusrc_next          = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Load in EX whose destination is a source of the instruction in ID.
    // A flush squashes the consumer anyway, so it suppresses the stall.
    assign stall = valid_IDEX && mem_IDEX[MEM_READ] && instr_valid &&
                   (instr20_16_IDEX != '0) &&
                   ((instr20_16_IDEX == rs_idx) || (instr20_16_IDEX == rt_idx)) &&
                   !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_IDEX      <= 1'b0;
            wb_IDEX         <= '0;
            mem_IDEX        <= '0;
            aluop_IDEX      <= '0;
            alusrc_IDEX     <= 1'b0;
            regdst_IDEX     <= 1'b0;
            pc_4_IDEX       <= '0;
            rs_IDEX         <= '0;
            rt_IDEX         <= '0;
            signExt_IDEX    <= '0;
            instr25_21_IDEX <= '0;
            instr20_16_IDEX <= '0;
            instr15_11_IDEX <= '0;
        end else begin
            // Datapath fields load unconditionally; a bubble is defined
            // purely by its cleared valid and control bits.
            pc_4_IDEX       <= pc_4;
            rs_IDEX         <= rs_data;
            rt_IDEX         <= rt_data;
            signExt_IDEX    <= sign_ext;
            instr25_21_IDEX <= rs_idx;
            instr20_16_IDEX <= rt_idx;
            instr15_11_IDEX <= rd_idx;
            if (flush || stall) begin
                valid_IDEX  <= 1'b0;
                wb_IDEX     <= '0;
                mem_IDEX    <= '0;
                aluop_IDEX  <= '0;
                alusrc_IDEX <= 1'b0;
                regdst_IDEX <= 1'b0;
            end else begin
                valid_IDEX  <= instr_valid;
                wb_IDEX     <= wb_next;
                mem_IDEX    <= mem_next;
                aluop_IDEX  <= aluop_next;
                alusrc_IDEX <= alusrc_next;
                regdst_IDEX <= regdst_next;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_4;
    logic [31:0] instr;
    logic        instr_valid;
    logic [4:0]  write_reg_MEMWB;
    logic [31:0] write_data_WB;
    logic        write_en;
    logic        flush;

    logic        stall;
    logic        valid_IDEX;
    logic [1:0]  wb_IDEX;
    logic [2:0]  mem_IDEX;
    logic [1:0]  aluop_IDEX;
    logic        alusrc_IDEX;
    logic        regdst_IDEX;
    logic [31:0] pc_4_IDEX, rs_IDEX, rt_IDEX, signExt_IDEX;
    logic [4:0]  instr25_21_IDEX, instr20_16_IDEX, instr15_11_IDEX;

    // 64-bit instance, used for the wide sign-extension checks
    logic        stall_w;
    logic        valid_w;
    logic [1:0]  wb_w;
    logic [2:0]  mem_w;
    logic [1:0]  aluop_w;
    logic        alusrc_w;
    logic        regdst_w;
    logic [63:0] pc_w, rs_w, rt_w, sx_w;
    logic [4:0]  i1_w, i2_w, i3_w;

    always #5 clk = ~clk;

    decode_stage_p dut (
        .clk(clk), .rst(rst), .pc_4(pc_4), .instr(instr), .instr_valid(instr_valid),
        .write_reg_MEMWB(write_reg_MEMWB), .write_data_WB(write_data_WB),
        .write_en(write_en), .flush(flush), .stall(stall), .valid_IDEX(valid_IDEX),
        .wb_IDEX(wb_IDEX), .mem_IDEX(mem_IDEX), .aluop_IDEX(aluop_IDEX),
        .alusrc_IDEX(alusrc_IDEX), .regdst_IDEX(regdst_IDEX), .pc_4_IDEX(pc_4_IDEX),
        .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX), .signExt_IDEX(signExt_IDEX),
        .instr25_21_IDEX(instr25_21_IDEX), .instr20_16_IDEX(instr20_16_IDEX),
        .instr15_11_IDEX(instr15_11_IDEX)
    );

    decode_stage_p #(.XLEN(64), .NREG(32), .RAW(5)) dut64 (
        .clk(clk), .rst(rst), .pc_4({32'h0, pc_4}), .instr(instr), .instr_valid(instr_valid),
        .write_reg_MEMWB(write_reg_MEMWB), .write_data_WB({write_data_WB, write_data_WB}),
        .write_en(write_en), .flush(flush), .stall(stall_w), .valid_IDEX(valid_w),
        .wb_IDEX(wb_w), .mem_IDEX(mem_w), .aluop_IDEX(aluop_w),
        .alusrc_IDEX(alusrc_w), .regdst_IDEX(regdst_w), .pc_4_IDEX(pc_w),
        .rs_IDEX(rs_w), .rt_IDEX(rt_w), .signExt_IDEX(sx_w),
        .instr25_21_IDEX(i1_w), .instr20_16_IDEX(i2_w), .instr15_11_IDEX(i3_w)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: architectural registers and the expected ID/EX contents.
    logic [31:0] m_regs [32];
    logic        m_valid, m_alusrc, m_regdst, m_bubble, m_known;
    logic [1:0]  m_wb, m_aluop;
    logic [2:0]  m_mem;
    logic [31:0] m_pc, m_rs, m_rt, m_sx;
    logic [63:0] m_sx64;
    logic [4:0]  m_i1, m_i2, m_i3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Control table: {wb, mem, aluop, alusrc, regdst}
    function automatic logic [8:0] ctl(input logic [31:0] ins, input logic v);
        if (!v) return 9'b0;
        case (ins[31:26])
            6'h00:   return {2'b10, 3'b000, 2'b10, 1'b0, 1'b1};
            6'h23:   return {2'b11, 3'b010, 2'b00, 1'b1, 1'b0};
            6'h2B:   return {2'b00, 3'b001, 2'b00, 1'b1, 1'b0};
            6'h04:   return {2'b00, 3'b100, 2'b01, 1'b0, 1'b0};
            6'h08:   return {2'b10, 3'b000, 2'b00, 1'b1, 1'b0};
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (write_en && write_reg_MEMWB != 5'd0 && write_reg_MEMWB == idx) return write_data_WB;
        return m_regs[idx];
    endfunction

    task automatic step(input logic r, input logic [31:0] ins, input logic iv,
                        input logic [31:0] pc, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic fl);
        logic        e_stall;
        logic [8:0]  c;
        logic [31:0] e_rs, e_rt, e_sx;
        logic [4:0]  a, b;
        rst = r; instr = ins; instr_valid = iv; pc_4 = pc;
        write_en = we; write_reg_MEMWB = wr; write_data_WB = wd; flush = fl;
        #1;
        a = ins[25:21];
        b = ins[20:16];
        e_stall = m_valid && m_mem[1] && iv && (m_i2 != 5'd0) &&
                  ((m_i2 == a) || (m_i2 == b)) && !fl;
        if (m_known) chk("stall", {63'b0, stall}, {63'b0, e_stall});
        c    = ctl(ins, iv);
        e_rs = rd_model(a);
        e_rt = rd_model(b);
        e_sx = {{16{ins[15]}}, ins[15:0]};
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_wb = 0; m_mem = 0; m_aluop = 0; m_alusrc = 0; m_regdst = 0;
            m_pc = 0; m_rs = 0; m_rt = 0; m_sx = 0; m_sx64 = 0; m_i1 = 0; m_i2 = 0; m_i3 = 0;
            m_bubble = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else begin
            m_bubble = fl || e_stall;
            m_valid  = m_bubble ? 1'b0 : iv;
            {m_wb, m_mem, m_aluop, m_alusrc, m_regdst} = m_bubble ? 9'b0 : c;
            m_pc = pc; m_rs = e_rs; m_rt = e_rt; m_sx = e_sx;
            m_sx64 = {{48{ins[15]}}, ins[15:0]};
            m_i1 = a; m_i2 = b; m_i3 = ins[15:11];
            if (we && wr != 5'd0) m_regs[wr] = wd;
        end
        m_known = 1'b1;
        #1;
        chk("valid", {63'b0, valid_IDEX}, {63'b0, m_valid});
        chk("ctrl", {55'b0, wb_IDEX, mem_IDEX, aluop_IDEX, alusrc_IDEX, regdst_IDEX},
                    {55'b0, m_wb, m_mem, m_aluop, m_alusrc, m_regdst});
        if (!m_bubble) begin
            chk("pc_4", {32'b0, pc_4_IDEX}, {32'b0, m_pc});
            chk("rs", {32'b0, rs_IDEX}, {32'b0, m_rs});
            chk("rt", {32'b0, rt_IDEX}, {32'b0, m_rt});
            chk("signExt", {32'b0, signExt_IDEX}, {32'b0, m_sx});
            chk("idx", {49'b0, instr25_21_IDEX, instr20_16_IDEX, instr15_11_IDEX},
                       {49'b0, m_i1, m_i2, m_i3});
            chk("signExt64", sx_w, m_sx64);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [5:0]  ops [6];
        logic [31:0] ins;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h3F;
        m_known = 1'b0;
        m_valid = 0; m_mem = 0; m_i2 = 0; m_bubble = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        // Reset for two cycles with a lw present
        step(1, 32'h8C220004, 1, 32'h100, 0, 0, 0, 0);
        step(1, 32'h8C220004, 1, 32'h100, 0, 0, 0, 0);
        // add r3,r2,r0: register 2 reads 0 after reset
        step(0, 32'h00401820, 1, 32'h100, 0, 0, 0, 0);
        // lw r2,-4(r1)
        step(0, 32'h8C22FFFC, 1, 32'h104, 0, 0, 0, 0);
        // add r4,r3,r0 with writeback of r3 in the same cycle
        step(0, 32'h00602020, 1, 32'h108, 1, 5'd3, 32'hDEADBEEF, 0);
        // add r4,r0,r0 with writeback to r0
        step(0, 32'h00002020, 1, 32'h10C, 1, 5'd0, 32'h12345678, 0);
        // Load-use: lw r2,0(r1); add r5,r2,r3 stalls once then proceeds
        step(0, 32'h8C220000, 1, 32'h110, 0, 0, 0, 0);
        step(0, 32'h00432820, 1, 32'h114, 0, 0, 0, 0);
        step(0, 32'h00432820, 1, 32'h114, 0, 0, 0, 0);
        // Flush during a load-use stall
        step(0, 32'h8C220000, 1, 32'h118, 0, 0, 0, 0);
        step(0, 32'h00432820, 1, 32'h11C, 0, 0, 0, 1);
        step(0, 32'h00432820, 1, 32'h120, 0, 0, 0, 0);
        // addi r1,r0,-32768: wide sign extension of 0x8000
        step(0, 32'h20018000, 1, 32'h124, 0, 0, 0, 0);
        // Unknown opcode 0x3F
        step(0, 32'hFC000000, 1, 32'h128, 0, 0, 0, 0);
        // Reset arriving during a stall
        step(0, 32'h8C220000, 1, 32'h12C, 0, 0, 0, 0);
        step(1, 32'h00432820, 1, 32'h130, 0, 0, 0, 0);
        step(0, 32'h00432820, 1, 32'h130, 0, 0, 0, 0);

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            ins = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
            step(($urandom_range(0, 59) == 0), ins, ($urandom_range(0, 7) != 0),
                 $urandom, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                 $urandom, ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
